// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage_if
// Brief    : ID -> issue-stage -> ALU signal bundle. The 'master' modport is
//            the issue stage; 'slave' is the surrounding pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [REG_AW-1:0] id_rs1_addr;
    logic [REG_AW-1:0] id_rs2_addr;
    logic [REG_AW-1:0] id_rd_addr;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [2:0]        id_funct3;
    logic              id_funct7_b5;
    logic              id_is_rtype;
    logic              id_is_shift_imm;
    logic              id_use_pc;
    logic              id_use_imm;
    logic              id_is_branch;
    logic              id_is_load;
    logic              id_rd_wr;
    logic [XLEN-1:0]   ex_alu_result;
    logic              mem_rd_wr;
    logic [REG_AW-1:0] mem_rd_addr;
    logic [XLEN-1:0]   mem_data;
    logic              ex_ready;
    logic              ex_valid;
    logic              ex_branch;
    logic [3:0]        ex_func3;
    logic [XLEN-1:0]   ex_rs1;
    logic [XLEN-1:0]   ex_rs2;
    logic [XLEN-1:0]   ex_store_data;
    logic [REG_AW-1:0] ex_rd_addr;
    logic              ex_rd_wr;
    logic              ex_is_load;
    logic [XLEN-1:0]   ex_pc;

    modport master (
        input  flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm, id_funct3, id_funct7_b5,
               id_is_rtype, id_is_shift_imm, id_use_pc, id_use_imm,
               id_is_branch, id_is_load, id_rd_wr, ex_alu_result,
               mem_rd_wr, mem_rd_addr, mem_data, ex_ready,
        output id_ready, ex_valid, ex_branch, ex_func3, ex_rs1, ex_rs2,
               ex_store_data, ex_rd_addr, ex_rd_wr, ex_is_load, ex_pc
    );

    modport slave (
        output flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm, id_funct3, id_funct7_b5,
               id_is_rtype, id_is_shift_imm, id_use_pc, id_use_imm,
               id_is_branch, id_is_load, id_rd_wr, ex_alu_result,
               mem_rd_wr, mem_rd_addr, mem_data, ex_ready,
        input  id_ready, ex_valid, ex_branch, ex_func3, ex_rs1, ex_rs2,
               ex_store_data, ex_rd_addr, ex_rd_wr, ex_is_load, ex_pc
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Brief    : ID/EX register feeding the ALU: operand forwarding, op select,
//            load-use stall, back-pressure and flush. Optional shift-amount
//            masking is enabled by defining ALU_SHAMT_MASK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    alu_issue_stage_if.master   bus
);

    logic              r_valid;
    logic              r_branch;
    logic [3:0]        r_func;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;
    logic [XLEN-1:0]   r_store_data;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_rd_wr;
    logic              r_is_load;
    logic [XLEN-1:0]   r_pc;

    logic              w_alt_op;
    logic [3:0]        w_func;
    logic              w_ex_fwd_ok;
    logic [XLEN-1:0]   w_fwd_rs1;
    logic [XLEN-1:0]   w_fwd_rs2;
    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;
    logic              w_load_use;
    logic              w_advance;
    logic              w_id_ready;
    logic              w_capture;

    // Bit 30 only selects SUB/SRA for R-type and SRAI; ADDI's imm bit 30 is ignored.
    assign w_alt_op = bus.id_funct7_b5 &
                      (bus.id_is_rtype | (bus.id_is_shift_imm & (bus.id_funct3 == 3'd5)));
    assign w_func   = {w_alt_op, bus.id_funct3};

    // A held load has no result yet, so it is never a forwarding source here.
    assign w_ex_fwd_ok = r_valid & r_rd_wr & ~r_is_load;

    always_comb begin
        w_fwd_rs1 = bus.id_rs1_data;
        if (bus.id_rs1_addr == '0) begin
            w_fwd_rs1 = '0;
        end else if (w_ex_fwd_ok && (r_rd_addr == bus.id_rs1_addr)) begin
            w_fwd_rs1 = bus.ex_alu_result;
        end else if (bus.mem_rd_wr && (bus.mem_rd_addr == bus.id_rs1_addr)) begin
            w_fwd_rs1 = bus.mem_data;
        end
    end

    always_comb begin
        w_fwd_rs2 = bus.id_rs2_data;
        if (bus.id_rs2_addr == '0) begin
            w_fwd_rs2 = '0;
        end else if (w_ex_fwd_ok && (r_rd_addr == bus.id_rs2_addr)) begin
            w_fwd_rs2 = bus.ex_alu_result;
        end else if (bus.mem_rd_wr && (bus.mem_rd_addr == bus.id_rs2_addr)) begin
            w_fwd_rs2 = bus.mem_data;
        end
    end

    assign w_op1 = bus.id_use_pc ? bus.id_pc : w_fwd_rs1;

`ifdef ALU_SHAMT_MASK_EN
    localparam logic [3:0] c_op_sll = 4'd1;
    localparam logic [3:0] c_op_srl = 4'd5;
    localparam logic [3:0] c_op_sra = 4'd13;

    // Shifters only honour the low five bits of the amount.
    always_comb begin
        w_op2 = bus.id_use_imm ? bus.id_imm : w_fwd_rs2;
        if (!bus.id_is_branch &&
            ((w_func == c_op_sll) || (w_func == c_op_srl) || (w_func == c_op_sra))) begin
            w_op2 = {{(XLEN-5){1'b0}}, w_op2[4:0]};
        end
    end
`else
    assign w_op2 = bus.id_use_imm ? bus.id_imm : w_fwd_rs2;
`endif

    // rs2 is compared even for immediate forms, since stores still need it.
    assign w_load_use = r_valid & r_is_load & (r_rd_addr != '0) &
                        (((r_rd_addr == bus.id_rs1_addr) & ~bus.id_use_pc) |
                         (r_rd_addr == bus.id_rs2_addr));

    assign w_advance  = ~r_valid | bus.ex_ready;
    assign w_id_ready = w_advance & ~w_load_use & ~bus.flush;
    assign w_capture  = bus.id_valid & w_id_ready;

    // Payload is only loaded on capture; consumers qualify it with ex_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_branch     <= 1'b0;
            r_func       <= 4'd0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_store_data <= '0;
            r_rd_addr    <= '0;
            r_rd_wr      <= 1'b0;
            r_is_load    <= 1'b0;
            r_pc         <= '0;
        end else if (bus.flush) begin
            r_valid      <= 1'b0;
        end else if (w_capture) begin
            r_valid      <= 1'b1;
            r_branch     <= bus.id_is_branch;
            r_func       <= w_func;
            r_rs1        <= w_op1;
            r_rs2        <= w_op2;
            r_store_data <= w_fwd_rs2;
            r_rd_addr    <= bus.id_rd_addr;
            r_rd_wr      <= bus.id_rd_wr;
            r_is_load    <= bus.id_is_load;
            r_pc         <= bus.id_pc;
        end else if (w_advance) begin
            r_valid      <= 1'b0;
        end
    end

    assign bus.id_ready      = w_id_ready;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_branch     = r_branch;
    assign bus.ex_func3      = r_func;
    assign bus.ex_rs1        = r_rs1;
    assign bus.ex_rs2        = r_rs2;
    assign bus.ex_store_data = r_store_data;
    assign bus.ex_rd_addr    = r_rd_addr;
    assign bus.ex_rd_wr      = r_rd_wr;
    assign bus.ex_is_load    = r_is_load;
    assign bus.ex_pc         = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Brief    : Scoreboard bench for alu_issue_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    typedef struct packed {
        logic [3:0]  func;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rdwr;
        logic        ld;
        logic        br;
        logic [31:0] pc;
    } exp_t;

`ifdef ALU_SHAMT_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    exp_t e;
    exp_t obs;

    alu_issue_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic exp_t observe();
        exp_t o;
        o = '{bus.ex_func3, bus.ex_rs1, bus.ex_rs2, bus.ex_store_data, bus.ex_rd_addr,
              bus.ex_rd_wr, bus.ex_is_load, bus.ex_branch, bus.ex_pc};
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_id();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0;
        bus.id_rd_addr = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
        bus.id_funct3 = 0; bus.id_funct7_b5 = 0; bus.id_is_rtype = 0;
        bus.id_is_shift_imm = 0; bus.id_use_pc = 0; bus.id_use_imm = 0;
        bus.id_is_branch = 0; bus.id_is_load = 0; bus.id_rd_wr = 0;
    endtask

    task automatic rtype(input logic [2:0] f3, input logic b5, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] pc);
        idle_id();
        bus.id_valid = 1; bus.id_is_rtype = 1; bus.id_rd_wr = 1;
        bus.id_funct3 = f3; bus.id_funct7_b5 = b5; bus.id_pc = pc;
        bus.id_rs1_addr = rs1; bus.id_rs2_addr = rs2; bus.id_rd_addr = rd;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2;
    endtask

    task automatic test_reset();
        rst_n = 0; bus.flush = 0; bus.ex_ready = 1; bus.ex_alu_result = 0;
        bus.mem_rd_wr = 0; bus.mem_rd_addr = 0; bus.mem_data = 0;
        idle_id();
        repeat (2) @(negedge clk);
        rst_n = 1;
        rtype(3'd0, 1'b0, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 32'h80);
        sb.push_back('{4'd0, 32'd1, 32'd2, 32'd2, 5'd9, 1'b1, 1'b0, 1'b0, 32'h80});
        step();
        idle_id();
        n_checks++;
        if (bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_valid: got %b want 1", bus.ex_valid);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++; $display("FAIL pre_reset_sb: got empty queue want 1 entry");
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL pre_reset_out: got %h want %h", obs, e);
            end
        end
        rst_n = 0;
        #1;
        n_checks++;
        if (bus.ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_valid: got %b want 0", bus.ex_valid);
        end
        obs = observe(); n_checks++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL rst_outputs: got %h want 0", obs);
        end
        @(negedge clk);
        rst_n = 1;
        rtype(3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h100);
        #1;
        n_checks++;
        if (bus.id_ready !== 1'b1) begin
            n_fail++; $display("FAIL first_id_ready: got %b want 1", bus.id_ready);
        end
        sb.push_back('{4'd0, 32'd5, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'h100});
        step();
        idle_id();
        n_checks++;
        if (sb.size() == 0 || bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL first_add_valid: got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL first_add: got %h want %h", obs, e);
            end
        end
    endtask

    task automatic test_opsel();
        exp_t exp_list[3];
        // SUB x5,x1,x2
        rtype(3'd0, 1'b1, 5'd1, 5'd2, 5'd5, 32'd20, 32'd3, 32'h104);
        exp_list[0] = '{4'd8, 32'd20, 32'd3, 32'd3, 5'd5, 1'b1, 1'b0, 1'b0, 32'h104};
        sb.push_back(exp_list[0]);
        step();
        // SRAI x5,x4,3 (imm field 0x403)
        idle_id();
        bus.id_valid = 1; bus.id_is_shift_imm = 1; bus.id_funct3 = 3'd5; bus.id_funct7_b5 = 1;
        bus.id_use_imm = 1; bus.id_imm = 32'h403; bus.id_rd_wr = 1; bus.id_pc = 32'h108;
        bus.id_rs1_addr = 5'd4; bus.id_rs2_addr = 5'd3; bus.id_rd_addr = 5'd5;
        bus.id_rs1_data = 32'h8000_0000; bus.id_rs2_data = 32'd0;
        exp_list[1] = '{4'd13, 32'h8000_0000, (MASK_EN ? 32'd3 : 32'h403), 32'd0, 5'd5,
                        1'b1, 1'b0, 1'b0, 32'h108};
        n_checks++;
        if (sb.size() == 0 || bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL sub_valid: got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL sub_op: got %h want %h", obs, e);
            end
        end
        sb.push_back(exp_list[1]);
        step();
        // ADDI x6,x1,0x400 (imm bit 10 mirrors instruction bit 30)
        idle_id();
        bus.id_valid = 1; bus.id_funct3 = 3'd0; bus.id_funct7_b5 = 1; bus.id_use_imm = 1;
        bus.id_imm = 32'h400; bus.id_rd_wr = 1; bus.id_pc = 32'h10c;
        bus.id_rs1_addr = 5'd1; bus.id_rd_addr = 5'd6; bus.id_rs1_data = 32'd1;
        exp_list[2] = '{4'd0, 32'd1, 32'h400, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h10c};
        n_checks++;
        if (sb.size() == 0 || bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL srai_valid: got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL srai_op: got %h want %h", obs, e);
            end
        end
        sb.push_back(exp_list[2]);
        step();
        idle_id();
        n_checks++;
        if (sb.size() == 0 || bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL addi_valid: got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL addi_op: got %h want %h", obs, e);
            end
        end
    endtask

    task automatic test_forwarding();
        // ADDI x1,x0,10 with a stale nonzero rs1 read
        idle_id();
        bus.id_valid = 1; bus.id_use_imm = 1; bus.id_imm = 32'd10; bus.id_rd_wr = 1;
        bus.id_rs1_addr = 5'd0; bus.id_rs1_data = 32'h55; bus.id_rd_addr = 5'd1;
        bus.id_pc = 32'h200;
        sb.push_back('{4'd0, 32'd0, 32'd10, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h200});
        step();
        n_checks++;
        if (sb.size() == 0 || bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL addi_x1_valid: got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL addi_x1: got %h want %h", obs, e);
            end
        end
        // ADD x2,x1,x1: EX result beats MEM and stale file data
        rtype(3'd0, 1'b0, 5'd1, 5'd1, 5'd2, 32'd3, 32'd3, 32'h204);
        bus.ex_alu_result = 32'd10;
        bus.mem_rd_wr = 1; bus.mem_rd_addr = 5'd1; bus.mem_data = 32'd99;
        sb.push_back('{4'd0, 32'd10, 32'd10, 32'd10, 5'd2, 1'b1, 1'b0, 1'b0, 32'h204});
        step();
        n_checks++;
        if (sb.size() == 0 || bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL fwd_ex_valid: got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL fwd_ex_prio: got %h want %h", obs, e);
            end
        end
        // ADD x3,x0,x0 with MEM claiming x0
        rtype(3'd0, 1'b0, 5'd0, 5'd0, 5'd3, 32'h77, 32'h77, 32'h208);
        bus.ex_alu_result = 32'd17;
        bus.mem_rd_wr = 1; bus.mem_rd_addr = 5'd0; bus.mem_data = 32'd99;
        sb.push_back('{4'd0, 32'd0, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h208});
        step();
        n_checks++;
        if (sb.size() == 0 || bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL fwd_x0_valid: got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL fwd_x0: got %h want %h", obs, e);
            end
        end
        // ADD x4,x5,x6 with MEM writing x5 only
        rtype(3'd0, 1'b0, 5'd5, 5'd6, 5'd4, 32'h1, 32'h66, 32'h20c);
        bus.mem_rd_wr = 1; bus.mem_rd_addr = 5'd5; bus.mem_data = 32'h1234;
        sb.push_back('{4'd0, 32'h1234, 32'h66, 32'h66, 5'd4, 1'b1, 1'b0, 1'b0, 32'h20c});
        step();
        idle_id();
        bus.mem_rd_wr = 0;
        n_checks++;
        if (sb.size() == 0 || bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL fwd_mem_valid: got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL fwd_mem: got %h want %h", obs, e);
            end
        end
    endtask

    task automatic test_load_use();
        // LW x6,8(x1)
        idle_id();
        bus.id_valid = 1; bus.id_is_load = 1; bus.id_rd_wr = 1; bus.id_use_imm = 1;
        bus.id_imm = 32'd8; bus.id_funct3 = 3'd2; bus.id_rs1_addr = 5'd1;
        bus.id_rs1_data = 32'h100; bus.id_rd_addr = 5'd6; bus.id_pc = 32'h300;
        sb.push_back('{4'd2, 32'h100, 32'd8, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0, 32'h300});
        step();
        n_checks++;
        if (sb.size() == 0 || bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL lw_valid: got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL lw_out: got %h want %h", obs, e);
            end
        end
        // ADD x7,x6,x1 depends on the load
        rtype(3'd0, 1'b0, 5'd6, 5'd1, 5'd7, 32'hdead, 32'h100, 32'h304);
        bus.ex_alu_result = 32'hbad0;
        #1;
        n_checks++;
        if (bus.id_ready !== 1'b0) begin
            n_fail++; $display("FAIL lu_stall_ready: got %b want 0", bus.id_ready);
        end
        step();
        n_checks++;
        if (bus.ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL lu_bubble: got %b want 0", bus.ex_valid);
        end
        bus.mem_rd_wr = 1; bus.mem_rd_addr = 5'd6; bus.mem_data = 32'hcafe;
        #1;
        n_checks++;
        if (bus.id_ready !== 1'b1) begin
            n_fail++; $display("FAIL lu_resume_ready: got %b want 1", bus.id_ready);
        end
        sb.push_back('{4'd0, 32'hcafe, 32'h100, 32'h100, 5'd7, 1'b1, 1'b0, 1'b0, 32'h304});
        step();
        idle_id();
        bus.mem_rd_wr = 0;
        n_checks++;
        if (sb.size() == 0 || bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL lu_add_valid: got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL lu_add: got %h want %h", obs, e);
            end
        end
    endtask

    task automatic test_backpressure_flush();
        exp_t held;
        rtype(3'd0, 1'b0, 5'd11, 5'd12, 5'd8, 32'h11, 32'h22, 32'h400);
        held = '{4'd0, 32'h11, 32'h22, 32'h22, 5'd8, 1'b1, 1'b0, 1'b0, 32'h400};
        sb.push_back(held);
        step();
        n_checks++;
        if (sb.size() == 0 || bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_first_valid: got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL bp_first: got %h want %h", obs, e);
            end
        end
        bus.ex_ready = 0;
        rtype(3'd0, 1'b0, 5'd13, 5'd14, 5'd9, 32'h33, 32'h44, 32'h404);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bus.id_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_ready_%0d: got %b want 0", i, bus.id_ready);
            end
            step();
            obs = observe(); n_checks++;
            if (bus.ex_valid !== 1'b1 || obs !== held) begin
                n_fail++; $display("FAIL bp_hold_%0d: got v=%b %h want v=1 %h",
                                   i, bus.ex_valid, obs, held);
            end
        end
        bus.flush = 1;
        #1;
        n_checks++;
        if (bus.id_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_ready: got %b want 0", bus.id_ready);
        end
        step();
        bus.flush = 0;
        n_checks++;
        if (bus.ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall_valid: got %b want 0", bus.ex_valid);
        end
        bus.ex_ready = 1;
        sb.push_back('{4'd0, 32'h33, 32'h44, 32'h44, 5'd9, 1'b1, 1'b0, 1'b0, 32'h404});
        step();
        n_checks++;
        if (sb.size() == 0 || bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_retry_valid: got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL bp_retry: got %h want %h", obs, e);
            end
        end
        // Flush coincident with an offered instruction drops it.
        rtype(3'd0, 1'b0, 5'd15, 5'd16, 5'd11, 32'h5, 32'h6, 32'h408);
        bus.flush = 1;
        #1;
        n_checks++;
        if (bus.id_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_xfer_ready: got %b want 0", bus.id_ready);
        end
        step();
        bus.flush = 0;
        idle_id();
        n_checks++;
        if (bus.ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_xfer_valid: got %b want 0", bus.ex_valid);
        end
    endtask

    task automatic test_shamt();
        // SLL x10,x1,x2 with rs2 = 0x21
        rtype(3'd1, 1'b0, 5'd1, 5'd2, 5'd10, 32'hf, 32'h21, 32'h500);
        sb.push_back('{4'd1, 32'hf, (MASK_EN ? 32'd1 : 32'h21), 32'h21, 5'd10,
                       1'b1, 1'b0, 1'b0, 32'h500});
        step();
        // BNE x1,x2: branch compare keeps the full rs2
        idle_id();
        bus.id_valid = 1; bus.id_is_branch = 1; bus.id_funct3 = 3'd1; bus.id_pc = 32'h504;
        bus.id_rs1_addr = 5'd1; bus.id_rs2_addr = 5'd2;
        bus.id_rs1_data = 32'd5; bus.id_rs2_data = 32'h21;
        n_checks++;
        if (sb.size() == 0 || bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL sll_valid: got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL sll_shamt: got %h want %h", obs, e);
            end
        end
        sb.push_back('{4'd1, 32'd5, 32'h21, 32'h21, 5'd0, 1'b0, 1'b0, 1'b1, 32'h504});
        step();
        idle_id();
        n_checks++;
        if (sb.size() == 0 || bus.ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL bne_valid: got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front(); obs = observe(); n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL bne_out: got %h want %h", obs, e);
            end
        end
        step();
        n_checks++;
        if (bus.ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_valid: got %b want 0", bus.ex_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_opsel();
        test_forwarding();
        test_load_use();
        test_backpressure_flush();
        test_shamt();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_empty: got %0d entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the execute ALU.
- Accepts decoded instructions from ID and resolves operands by forwarding and PC/immediate selection.
- Builds the ALU's 4-bit operation select, registers everything, and presents it to the ALU for one cycle per instruction.
- Handles load-use stalls, downstream back-pressure and branch flushes.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- flush  in  1  kill held instruction (taken branch/jump)
- id_valid  in  1  ID presents instruction
- id_ready  out  1  stage accepts instruction this cycle
- id_pc  in  XLEN  instruction PC
- id_rs1_addr / id_rs2_addr / id_rd_addr  in  REG_AW  register indices
- id_rs1_data / id_rs2_data  in  XLEN  register-file read data (write-through file)
- id_imm  in  XLEN  sign-extended immediate
- id_funct3  in  3  instruction funct3
- id_funct7_b5  in  1  instruction bit 30
- id_is_rtype  in  1  R-type (bit 30 honoured for SUB/SRA)
- id_is_shift_imm  in  1  SLLI/SRLI/SRAI
- id_use_pc  in  1  operand A = PC
- id_use_imm  in  1  operand B = imm
- id_is_branch  in  1  conditional branch
- id_is_load  in  1  load instruction
- id_rd_wr  in  1  instruction writes rd
- ex_alu_result  in  XLEN  ALU result of held instruction (fed back)
- mem_rd_wr  in  1  MEM stage writes rd
- mem_rd_addr  in  REG_AW  MEM stage rd
- mem_data  in  XLEN  MEM stage result
- ex_ready  in  1  execute accepts held instruction
- ex_valid  out  1  held instruction valid
- ex_branch  out  1  ALU branch input
- ex_func3  out  4  ALU operation select
- ex_rs1 / ex_rs2  out  XLEN  ALU operands
- ex_store_data  out  XLEN  forwarded rs2 for stores
- ex_rd_addr  out  REG_AW  destination
- ex_rd_wr / ex_is_load  out  1  pass-through flags
- ex_pc  out  XLEN  PC pass-through

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While asserted, every registered output is 0. id_ready is combinational.
- Operation select: ex_func3 = {b, id_funct3}, where b = id_funct7_b5 & (id_is_rtype | (id_is_shift_imm & id_funct3==5)).
  - Yields 8 = SUB and 13 = SRA. ADDI never yields 8.
  - ex_branch = id_is_branch.
- Forwarding, per source register, evaluated combinationally at capture:
  - Address 0 → 0.
  - Else if held instruction is ex_valid & ex_rd_wr & !ex_is_load & ex_rd_addr matches → ex_alu_result.
  - Else if mem_rd_wr & mem_rd_addr matches → mem_data.
  - Else register-file data. EX has priority over MEM.
- Operands:
  - ex_rs1 = id_use_pc ? id_pc : fwd_rs1.
  - ex_rs2 = id_use_imm ? id_imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
  - Branches set id_use_imm=0.
- Load-use hazard: load_use = ex_valid & ex_is_load & ex_rd_addr!=0 & (ex_rd_addr==id_rs1_addr & !id_use_pc | ex_rd_addr==id_rs2_addr).
  - Compare rs2 regardless of id_use_imm (stores need it).
- Handshake: advance = !ex_valid | ex_ready; id_ready = advance & !load_use & !flush.
- Register update at clock edge, in priority order:
  1. flush → ex_valid=0.
  2. Else if advance & id_valid & id_ready → capture; ex_valid=1.
  3. Else if advance → ex_valid=0 (bubble; covers load-use).
  4. Else hold all outputs unchanged.
- Latency: one cycle, ID acceptance to ex_valid. Full throughput absent hazards.
- Load-use costs exactly one bubble. On the next cycle the load has left, and its data arrives via mem_data.
- flush with ex_ready=0 still clears ex_valid. A flush on the same edge as an id transfer drops that instruction (id_ready=0).
- Payload registers need not clear on bubble; consumers qualify with ex_valid.

Optional Feature:
- ALU_SHAMT_MASK_EN.
  - Defined: for shift ops (ex_func3 in {1,5,13}, ex_branch=0), ex_rs2 is zero-extended from bits [4:0]. SLL by 33 then behaves as shift by 1, per RV32I.
  - Undefined: ex_rs2 passes unmasked.

Test Plan:
- Reset asserted mid-stream with ex_valid=1 → all outputs 0 immediately. After release, first accepted ADD x3,x1,x2 (x1=5,x2=7) gives ex_func3=0, ex_rs1=5, ex_rs2=7 one cycle later.
- SUB then SRAI x5,x4,3 (bit30=1) → ex_func3=8 then 13. ADDI with imm bit30 set → ex_func3=0.
- Back-to-back ADD x1=10; ADD x2,x1,x1 with ex_alu_result=10 and mem_data=99 to x1 → ex_rs1=ex_rs2=10 (EX priority). Source x0 → 0 even if mem_rd_addr=0.
- LW x6 then ADD x7,x6,x1 → id_ready=0 for one cycle, one bubble (ex_valid=0). Next cycle ADD captured with mem_data forwarded.
- ex_ready=0 for 3 cycles → outputs stable, id_ready=0. flush during stall → ex_valid=0 next edge.
- With ALU_SHAMT_MASK_EN: SLL with rs2=0x21 → ex_rs2=1. Without it → ex_rs2=0x21.
